// File: rtl/branch_sequencer_if.sv
// rtl/branch_sequencer_if.sv - control/status bundle between the branch sequencer and its datapath
interface branch_sequencer_if;
  logic        start;
  logic [4:0]  opcode;
  logic [1:0]  c2;
  logic        hold;
  logic        con_ff;
  logic        cnt_clr;

  logic        gra;
  logic        r_out;
  logic        con_in;
  logic        pc_out;
  logic        y_in;
  logic        c_out;
  logic        alu_add;
  logic        z_in;
  logic        zlow_out;
  logic        pc_in;

  logic [1:0]  cond_q;
  logic        busy;
  logic        done;
  logic        taken;
  logic        err;
  logic [15:0] br_cnt;
  logic [15:0] taken_cnt;

  modport master (
    output start, opcode, c2, hold, con_ff, cnt_clr,
    input  gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in,
    input  cond_q, busy, done, taken, err, br_cnt, taken_cnt
  );

  modport slave (
    input  start, opcode, c2, hold, con_ff, cnt_clr,
    output gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in,
    output cond_q, busy, done, taken, err, br_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - T3..T6 control-step sequencer for conditional branches
module branch_sequencer #(
  parameter logic [4:0] BR_OPCODE = 5'b10010
) (
  input  logic               clk,
  input  logic               clr,
  branch_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, T3, T4, T5, T6} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cond_reg_q, cond_reg_d;
  logic        done_q, done_d;
  logic        taken_q, taken_d;
  logic        err_q, err_d;
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  // Next state, strobe decode and statistics; hold freezes state and silences strobes
  always_comb begin
    state_d      = state_q;
    cond_reg_d   = cond_reg_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    taken_d      = taken_q;
    br_cnt_d     = br_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    bus.gra      = 1'b0;
    bus.r_out    = 1'b0;
    bus.con_in   = 1'b0;
    bus.pc_out   = 1'b0;
    bus.y_in     = 1'b0;
    bus.c_out    = 1'b0;
    bus.alu_add  = 1'b0;
    bus.z_in     = 1'b0;
    bus.zlow_out = 1'b0;
    bus.pc_in    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.opcode == BR_OPCODE) begin
            state_d    = T3;
            cond_reg_d = bus.c2;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      T3: if (!bus.hold) begin
        bus.gra    = 1'b1;
        bus.r_out  = 1'b1;
        bus.con_in = 1'b1;
        state_d    = T4;
      end
      T4: if (!bus.hold) begin
        bus.pc_out = 1'b1;
        bus.y_in   = 1'b1;
        state_d    = T5;
      end
      T5: if (!bus.hold) begin
        bus.c_out   = 1'b1;
        bus.alu_add = 1'b1;
        bus.z_in    = 1'b1;
        state_d     = T6;
      end
      T6: if (!bus.hold) begin
        // The condition flip-flop is only meaningful here, after T3 loaded it
        bus.zlow_out = 1'b1;
        bus.pc_in    = bus.con_ff;
        state_d      = IDLE;
        done_d       = 1'b1;
        taken_d      = bus.con_ff;
      end
      default: state_d = IDLE;
    endcase

    // Counter clear wins over a completion landing on the same edge
    if (bus.cnt_clr) begin
      br_cnt_d    = 16'h0000;
      taken_cnt_d = 16'h0000;
    end else if (done_d) begin
      if (br_cnt_q != 16'hFFFF) br_cnt_d = br_cnt_q + 16'd1;
      if (bus.con_ff && (taken_cnt_q != 16'hFFFF)) taken_cnt_d = taken_cnt_q + 16'd1;
    end
  end

  // State and status registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      cond_reg_q  <= 2'b00;
      done_q      <= 1'b0;
      taken_q     <= 1'b0;
      err_q       <= 1'b0;
      br_cnt_q    <= 16'h0000;
      taken_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cond_reg_q  <= cond_reg_d;
      done_q      <= done_d;
      taken_q     <= taken_d;
      err_q       <= err_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign bus.cond_q    = cond_reg_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.taken     = taken_q;
  assign bus.err       = err_q;
  assign bus.br_cnt    = br_cnt_q;
  assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - scoreboard bench for branch_sequencer
module tb_branch_sequencer;

  localparam logic [4:0] BR  = 5'b10010;
  localparam logic [9:0] ST3 = 10'b1110000000;
  localparam logic [9:0] ST4 = 10'b0001100000;
  localparam logic [9:0] ST5 = 10'b0000011100;

  typedef struct {
    logic        taken;
    logic [15:0] br;
    logic [15:0] tk;
    logic [1:0]  cond;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [15:0] m_br, m_tk;
  logic        m_taken;

  always #5 clk = ~clk;

  branch_sequencer_if bus();

  branch_sequencer #(.BR_OPCODE(BR)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] strobes();
    return {bus.gra, bus.r_out, bus.con_in, bus.pc_out, bus.y_in,
            bus.c_out, bus.alu_add, bus.z_in, bus.zlow_out, bus.pc_in};
  endfunction

  // completion monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!clr && bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_taken", {31'd0, bus.taken}, {31'd0, mon_e.taken});
        check("done_br_cnt", {16'd0, bus.br_cnt}, {16'd0, mon_e.br});
        check("done_taken_cnt", {16'd0, bus.taken_cnt}, {16'd0, mon_e.tk});
        check("done_cond_q", {30'd0, bus.cond_q}, {30'd0, mon_e.cond});
      end
    end
  end

  // caller is between a negedge and the following posedge with the DUT idle
  task automatic run_branch(input logic [1:0] c, input logic cf, input int hold_n, input logic clr_cnt);
    exp_t e;
    bus.start  = 1'b1;
    bus.opcode = BR;
    bus.c2     = c;
    bus.con_ff = ~cf;
    if (clr_cnt) begin
      m_br = 16'h0000;
      m_tk = 16'h0000;
    end else begin
      if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
      if (cf && (m_tk != 16'hFFFF)) m_tk = m_tk + 16'd1;
    end
    m_taken = cf;
    e.taken = cf; e.br = m_br; e.tk = m_tk; e.cond = c;
    sb.push_back(e);

    @(negedge clk);
    bus.start = 1'b0;
    bus.c2    = ~c;
    #1;
    check("t3_strobes", {22'd0, strobes()}, {22'd0, ST3});
    check("t3_busy", {31'd0, bus.busy}, 32'd1);
    check("t3_done", {31'd0, bus.done}, 32'd0);
    check("t3_cond_q", {30'd0, bus.cond_q}, {30'd0, c});

    @(negedge clk);
    for (int i = 0; i < hold_n; i++) begin
      bus.hold = 1'b1;
      #1;
      check("hold_strobes", {22'd0, strobes()}, 32'd0);
      check("hold_busy", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
    end
    bus.hold = 1'b0;
    #1;
    check("t4_strobes", {22'd0, strobes()}, {22'd0, ST4});
    bus.start  = 1'b1;
    bus.opcode = 5'b00011;

    @(negedge clk);
    bus.start  = 1'b0;
    bus.opcode = BR;
    #1;
    check("t5_strobes", {22'd0, strobes()}, {22'd0, ST5});
    check("busy_err", {31'd0, bus.err}, 32'd0);

    @(negedge clk);
    bus.con_ff  = cf;
    bus.cnt_clr = clr_cnt;
    #1;
    check("t6_strobes", {22'd0, strobes()}, {22'd0, 9'b000000001, cf});
    check("t6_done", {31'd0, bus.done}, 32'd0);

    @(negedge clk);
    bus.cnt_clr = 1'b0;
    #1;
    check("end_done", {31'd0, bus.done}, 32'd1);
    check("end_busy", {31'd0, bus.busy}, 32'd0);
    check("end_strobes", {22'd0, strobes()}, 32'd0);
  endtask

  task automatic bad_opcode();
    bus.start  = 1'b1;
    bus.opcode = 5'b00011;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.opcode = BR;
    #1;
    check("bad_err", {31'd0, bus.err}, 32'd1);
    check("bad_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    #1;
    check("bad_err_end", {31'd0, bus.err}, 32'd0);
    check("bad_br_cnt", {16'd0, bus.br_cnt}, {16'd0, m_br});
    check("bad_taken_cnt", {16'd0, bus.taken_cnt}, {16'd0, m_tk});
    check("bad_taken", {31'd0, bus.taken}, {31'd0, m_taken});
  endtask

  task automatic abort_in_t5();
    bus.start  = 1'b1;
    bus.opcode = BR;
    bus.c2     = 2'b10;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_br = 16'h0000; m_tk = 16'h0000; m_taken = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_br_cnt", {16'd0, bus.br_cnt}, 32'd0);
    check("abort_taken_cnt", {16'd0, bus.taken_cnt}, 32'd0);
    check("abort_taken", {31'd0, bus.taken}, 32'd0);
    check("abort_strobes", {22'd0, strobes()}, 32'd0);
    @(negedge clk);
    #1;
    check("abort_no_done", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b1;
    bus.start = 1'b0; bus.opcode = 5'd0; bus.c2 = 2'd0;
    bus.hold = 1'b0; bus.con_ff = 1'b0; bus.cnt_clr = 1'b0;
    m_br = 16'h0000; m_tk = 16'h0000; m_taken = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_taken", {31'd0, bus.taken}, 32'd0);
    check("rst_cond_q", {30'd0, bus.cond_q}, 32'd0);
    check("rst_br_cnt", {16'd0, bus.br_cnt}, 32'd0);
    check("rst_taken_cnt", {16'd0, bus.taken_cnt}, 32'd0);
    check("rst_strobes", {22'd0, strobes()}, 32'd0);

    run_branch(2'b01, 1'b1, 0, 1'b0);
    run_branch(2'b01, 1'b0, 0, 1'b0);
    bad_opcode();
    run_branch(2'b10, 1'b1, 3, 1'b0);
    run_branch(2'b11, 1'b0, 0, 1'b0);
    run_branch(2'b00, 1'b1, 0, 1'b0);
    abort_in_t5();

    @(negedge clk);
    force dut.br_cnt_q    = 16'hFFFE;
    force dut.taken_cnt_q = 16'hFFFE;
    #1;
    release dut.br_cnt_q;
    release dut.taken_cnt_q;
    m_br = 16'hFFFE;
    m_tk = 16'hFFFE;
    @(negedge clk);
    #1;
    check("preload_br_cnt", {16'd0, bus.br_cnt}, {16'd0, m_br});
    run_branch(2'b00, 1'b1, 0, 1'b0);
    run_branch(2'b01, 1'b1, 0, 1'b0);
    run_branch(2'b10, 1'b1, 0, 1'b1);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter: BR_OPCODE, default 5'b10010, opcode of the conditional-branch instruction family.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 clr  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to execute a branch; sampled only in IDLE.
REQ-005 opcode  input  5  IR[31:27] of the current instruction.
REQ-006 c2  input  2  IR[20:19] condition field (00 zero, 01 nonzero, 10 positive, 11 negative).
REQ-007 hold  input  1  stall; freezes the sequence.
REQ-008 con_ff  input  1  output of the CON flip-flop.
REQ-009 cnt_clr  input  1  synchronous clear of both statistics counters.
REQ-010 gra, r_out, con_in  output  1 each  T3 strobes.
REQ-011 pc_out, y_in  output  1 each  T4 strobes.
REQ-012 c_out, alu_add, z_in  output  1 each  T5 strobes.
REQ-013 zlow_out, pc_in  output  1 each  T6 strobes.
REQ-014 cond_q  output  2  c2 latched at accept.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at completion.
REQ-017 taken  output  1  registered result of the last completed branch.
REQ-018 err  output  1  one-cycle pulse on a rejected start.
REQ-019 br_cnt, taken_cnt  output  16 each  completed and taken branch counters.

Function
REQ-020 States SHALL be IDLE, T3, T4, T5, T6, held in a registered state variable.
REQ-021 In IDLE with start=1 and opcode==BR_OPCODE: state SHALL move to T3 at the next edge and c2 SHALL be latched into cond_q.
REQ-022 In IDLE with start=1 and opcode!=BR_OPCODE: state SHALL remain IDLE and err SHALL pulse high for the next cycle.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 Transitions SHALL be T3->T4->T5->T6->IDLE, one per cycle when hold=0.
REQ-025 With hold=1 in T3..T6: state SHALL be frozen and all strobes SHALL be 0; the sequence SHALL resume in the same state when hold falls.
REQ-026 hold SHALL have no effect in IDLE.
REQ-027 Strobe decode (hold=0):
  - T3: gra=r_out=con_in=1.
  - T4: pc_out=y_in=1.
  - T5: c_out=alu_add=z_in=1.
  - T6: zlow_out=1; pc_in=con_ff.
REQ-028 All strobes SHALL be 0 in IDLE.
REQ-029 con_ff SHALL be sampled only in T6, never in T3.
REQ-030 On leaving T6: done SHALL pulse for one cycle and taken SHALL load con_ff; taken SHALL otherwise hold its value.
REQ-031 On leaving T6: br_cnt SHALL increment, and taken_cnt SHALL increment if con_ff=1.
REQ-032 Both counters SHALL saturate at 16'hFFFF with no wrap.
REQ-033 cnt_clr SHALL zero both counters at the next edge and SHALL take priority over a coincident increment.
REQ-034 Minimum start-to-done latency SHALL be 5 edges: accept, T3, T4, T5, T6.
REQ-035 A new start SHALL be acceptable in the cycle done is high, since the state is then IDLE.

Reset
REQ-036 clr=1 at any edge SHALL force IDLE and set cond_q=0, taken=0, done=0, err=0, br_cnt=0, taken_cnt=0; all strobes SHALL be 0 from that edge onward.
REQ-037 clr SHALL override start, hold and cnt_clr.
REQ-038 clr mid-sequence SHALL abort with no done pulse and no counter update.

Verification
REQ-039 Taken branch: start, opcode=10010, c2=01, con_ff=1 in T6 -> strobes in order T3..T6, pc_in=1 in T6, done after 5 edges, taken=1, br_cnt=1, taken_cnt=1.
REQ-040 Not-taken branch: same stimulus with con_ff=0 -> pc_in=0, zlow_out=1 in T6, taken=0, br_cnt=2, taken_cnt=1.
REQ-041 Bad opcode: start with opcode=00011 -> err pulses one cycle, busy stays 0, counters unchanged.
REQ-042 Stall: hold=1 for 3 cycles entering T4 -> all strobes 0 for 3 cycles, then pc_out/y_in asserted, done 3 cycles late.
REQ-043 Abort: clr in T5 -> next cycle IDLE, no done, counters and taken reset to 0.
REQ-044 Saturation and clear: preload via 65535 completed branches, run one more -> br_cnt stays FFFF; cnt_clr with coincident completion -> both counters 0.
